// File: rtl/medidor_pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM duty/period meter.
// Duty codes share the 10-bit 0..1023 scale of the current setpoint.
package medidor_pwm_pkg;

  localparam int DUTY_W = 10;
  localparam logic [DUTY_W-1:0] FULL_SCALE = 10'd1023;

  typedef enum logic [1:0] {
    IDLE,
    ESPERA,
    MIDE
  } estado_t;

endpackage

// File: rtl/divisor_secuencial.sv
// Restoring divider: cociente = floor(num*1024/den), one bit per cycle, 10 cycles from start to done.
// The caller guarantees num < den; abort (or reset) kills a division in flight and suppresses done.
module divisor_secuencial
  import medidor_pwm_pkg::*;
#(
  parameter int W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [W-1:0]      num,
  input  logic [W-1:0]      den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] cociente
);

  localparam logic [3:0] ITER_LAST = 4'(DUTY_W - 1);

  logic [W-1:0] rem;
  logic [W-1:0] den_q;
  logic [3:0]   iter;
  logic [W-1:0] rem_src;
  logic [W-1:0] den_src;
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic         ge;

  // The start cycle already performs the first iteration on the raw operands.
  always_comb begin
    rem_src = start ? num : rem;
    den_src = start ? den : den_q;
    shifted = {rem_src, 1'b0};
    diff    = shifted - {1'b0, den_src};
    ge      = (shifted >= {1'b0, den_src});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      den_q    <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cociente <= '0;
    end else if (abort) begin
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rem      <= ge ? diff[W-1:0] : shifted[W-1:0];
        cociente <= {cociente[DUTY_W-2:0], ge};
        if (start) begin
          busy  <= 1'b1;
          den_q <= den;
          iter  <= 4'd1;
        end else if (iter == ITER_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          iter <= iter + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/medidor_pwm.sv
// Measures an asynchronous PWM input: duty as floor(high*1024/period), plus period and stuck/overrun flags.
// valid pulses 12 cycles after the capturing rise; a rise arriving while the divider is busy is dropped (overrun).
module medidor_pwm
  import medidor_pwm_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 1000000,
  parameter int MIN_PERIOD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  input  logic              enable,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  periodo,
  output logic              valid,
  output logic              stuck,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_HOLD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);

  logic              sync_a, sync_b, sync_prev, rise;
  estado_t           state, state_nx;
  logic              arm, capture, timeout, abort, accept, drop;
  logic              start_q, div_busy, div_done;
  logic [DUTY_W-1:0] cociente;
  logic [CNT_W-1:0]  period_cnt, high_cnt, idle_cnt, snap_p, snap_h;

  assign rise = sync_b & ~sync_prev;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    abort    = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      abort    = 1'b1;
    end else begin
      case (state)
        IDLE:   state_nx = ESPERA;
        ESPERA: begin
          if (rise) begin
            arm      = 1'b1;
            state_nx = MIDE;
          end else if (idle_cnt == TO_LAST) begin
            timeout = 1'b1;
            abort   = 1'b1;
          end
        end
        MIDE: begin
          if (rise) begin
            capture = 1'b1;
          end else if (idle_cnt == TO_LAST) begin
            timeout  = 1'b1;
            abort    = 1'b1;
            state_nx = ESPERA;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // A pending start counts as busy so two snapshots never race into the divider.
    if (capture && period_cnt >= MIN_P) begin
      accept = ~(start_q | div_busy);
      drop   = start_q | div_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      sync_prev  <= 1'b0;
      start_q    <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      idle_cnt   <= '0;
      snap_p     <= '0;
      snap_h     <= '0;
      duty       <= '0;
      periodo    <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_a    <= pwm_in;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      start_q   <= accept;
      valid     <= 1'b0;

      if (arm || capture) begin
        period_cnt <= CNT_ONE;
        high_cnt   <= CNT_ONE;
      end else if (state == MIDE) begin
        if (period_cnt != CNT_MAX)          period_cnt <= period_cnt + CNT_ONE;
        if (sync_b && high_cnt != CNT_MAX)  high_cnt   <= high_cnt + CNT_ONE;
      end

      // After a timeout the idle counter parks above the threshold so a stuck line reports only once.
      if (state == IDLE || arm || capture) idle_cnt <= '0;
      else if (timeout)                    idle_cnt <= TO_HOLD;
      else if (idle_cnt != TO_HOLD)        idle_cnt <= idle_cnt + CNT_ONE;

      if (accept) begin
        snap_p <= period_cnt;
        snap_h <= high_cnt;
      end
      if (drop) overrun <= 1'b1;

      if (timeout) begin
        stuck   <= 1'b1;
        duty    <= sync_b ? FULL_SCALE : '0;
        periodo <= '0;
        valid   <= 1'b1;
      end else if (div_done && enable) begin
        stuck   <= 1'b0;
        duty    <= cociente;
        periodo <= snap_p;
        valid   <= 1'b1;
      end
    end
  end

  divisor_secuencial #(.W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (start_q),
    .abort    (abort),
    .num      (snap_h),
    .den      (snap_p),
    .busy     (div_busy),
    .done     (div_done),
    .cociente (cociente)
  );

endmodule
